// File: rtl/rf_writeback_unit.sv
// Register-file writeback initiator: in-order result FIFO from load/ALU producers,
// one registered write per cycle, plus a pending-register scoreboard for RAW stalls.
module rf_writeback_unit #(
    parameter int unsigned XLEN   = 64,
    parameter int unsigned REG_AW = 5,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       alu_valid,
    output logic                       alu_ready,
    input  logic [REG_AW-1:0]          alu_rd,
    input  logic [XLEN-1:0]            alu_data,
    input  logic                       mem_valid,
    output logic                       mem_ready,
    input  logic [REG_AW-1:0]          mem_rd,
    input  logic [XLEN-1:0]            mem_data,
    input  logic                       issue_reserve,
    input  logic [REG_AW-1:0]          issue_rd,
    input  logic [REG_AW-1:0]          query_rs1,
    input  logic [REG_AW-1:0]          query_rs2,
    output logic                       rs1_busy,
    output logic                       rs2_busy,
    output logic                       rf_write_enable,
    output logic [REG_AW-1:0]          rf_rd,
    output logic [XLEN-1:0]            rf_write_data,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic                       idle,
    output logic                       err
);
    localparam int unsigned PW   = $clog2(DEPTH);
    localparam int unsigned CW   = PW + 1;
    localparam int unsigned NREG = 1 << REG_AW;

    logic [REG_AW-1:0] fifo_rd_q   [DEPTH];
    logic [XLEN-1:0]   fifo_data_q [DEPTH];
    logic [PW-1:0]     wptr_q, rptr_q;
    logic [CW-1:0]     count_q, count_d;
    logic [NREG-1:0]   pending_q, pending_d;
    logic              err_q, err_d;
    logic              rf_we_q;
    logic [REG_AW-1:0] rf_rd_q;
    logic [XLEN-1:0]   rf_data_q;

    logic              space, push_mem, push_alu, push, pop;
    logic [REG_AW-1:0] push_rd, head_rd;
    logic [XLEN-1:0]   push_data;

    always_comb begin
        // Ready is a function of the registered count only; a same-cycle pop never makes room.
        space     = count_q < CW'(DEPTH);
        mem_ready = rst_n && space;
        alu_ready = rst_n && space && !mem_valid;
        push_mem  = mem_valid && mem_ready;
        push_alu  = alu_valid && alu_ready;
        push      = push_mem || push_alu;
        push_rd   = push_mem ? mem_rd : alu_rd;
        push_data = push_mem ? mem_data : alu_data;
        pop       = count_q != '0;
        head_rd   = fifo_rd_q[rptr_q];
        count_d   = count_q + CW'(push) - CW'(pop);

        pending_d = pending_q;
        if (pop) pending_d[head_rd] = 1'b0;
        // Reservation is applied after the clear so set wins on a collision.
        if (issue_reserve && issue_rd != '0) pending_d[issue_rd] = 1'b1;
        pending_d[0] = 1'b0;

        err_d = err_q
              | (issue_reserve && issue_rd != '0 && pending_q[issue_rd])
              | (push && push_rd != '0 && !pending_q[push_rd]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                fifo_rd_q[i]   <= '0;
                fifo_data_q[i] <= '0;
            end
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
            pending_q <= '0;
            err_q     <= 1'b0;
            rf_we_q   <= 1'b0;
            rf_rd_q   <= '0;
            rf_data_q <= '0;
        end else begin
            if (push) begin
                fifo_rd_q[wptr_q]   <= push_rd;
                fifo_data_q[wptr_q] <= push_data;
                wptr_q              <= wptr_q + PW'(1);
            end
            if (pop) begin
                rptr_q    <= rptr_q + PW'(1);
                rf_rd_q   <= head_rd;
                rf_data_q <= fifo_data_q[rptr_q];
                rf_we_q   <= head_rd != '0;
            end else begin
                rf_we_q   <= 1'b0;
            end
            count_q   <= count_d;
            pending_q <= pending_d;
            err_q     <= err_d;
        end
    end

    assign rs1_busy        = pending_q[query_rs1];
    assign rs2_busy        = pending_q[query_rs2];
    assign rf_write_enable = rf_we_q;
    assign rf_rd           = rf_rd_q;
    assign rf_write_data   = rf_data_q;
    assign fifo_count      = count_q;
    assign idle            = (count_q == '0) && !rf_we_q;
    assign err             = err_q;
endmodule

// File: tb/tb_rf_writeback_unit.sv
// Bench for rf_writeback_unit: directed scenarios plus randomized traffic checked against
// a queue-based model of the writeback path and scoreboard.
`timescale 1ns/1ps
module tb_rf_writeback_unit;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        alu_valid = 1'b0, mem_valid = 1'b0, issue_reserve = 1'b0;
    logic        alu_ready, mem_ready, rs1_busy, rs2_busy;
    logic [4:0]  alu_rd = '0, mem_rd = '0, issue_rd = '0, query_rs1 = '0, query_rs2 = '0;
    logic [63:0] alu_data = '0, mem_data = '0;
    logic        rf_write_enable, idle, err;
    logic [4:0]  rf_rd;
    logic [63:0] rf_write_data;
    logic [2:0]  fifo_count;

    int n_tests = 0;
    int n_fail  = 0;

    rf_writeback_unit #(.XLEN(64), .REG_AW(5), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
        .issue_reserve(issue_reserve), .issue_rd(issue_rd),
        .query_rs1(query_rs1), .query_rs2(query_rs2),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .rf_write_enable(rf_write_enable), .rf_rd(rf_rd), .rf_write_data(rf_write_data),
        .fifo_count(fifo_count), .idle(idle), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic [63:0] data;
    } ent_t;

    ent_t        mq[$];
    bit          m_pend[32];
    bit          m_err;
    logic        m_we;
    logic [4:0]  m_rd;
    logic [63:0] m_data;

    task automatic model_clear();
        mq.delete();
        foreach (m_pend[i]) m_pend[i] = 0;
        m_err  = 0;
        m_we   = 0;
        m_rd   = '0;
        m_data = '0;
    endtask

    task automatic idle_inputs();
        alu_valid = 0; mem_valid = 0; issue_reserve = 0;
    endtask

    // Advances the model by one edge using the inputs currently driven, then clocks the DUT.
    task automatic tick();
        int   sz;
        bit   macc, aacc;
        ent_t e, h;
        sz   = mq.size();
        macc = mem_valid && (sz < DEPTH);
        aacc = alu_valid && (sz < DEPTH) && !mem_valid;
        e.rd = '0; e.data = '0;
        if (macc) begin e.rd = mem_rd; e.data = mem_data; end
        else if (aacc) begin e.rd = alu_rd; e.data = alu_data; end
        if (issue_reserve && issue_rd != 0 && m_pend[issue_rd]) m_err = 1;
        if ((macc || aacc) && e.rd != 0 && !m_pend[e.rd]) m_err = 1;
        if (sz > 0) begin
            h = mq.pop_front();
            m_we = (h.rd != 0); m_rd = h.rd; m_data = h.data;
            m_pend[h.rd] = 0;
        end else begin
            m_we = 0;
        end
        if (issue_reserve && issue_rd != 0) m_pend[issue_rd] = 1;
        if (macc || aacc) mq.push_back(e);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 0;
        model_clear();
        @(posedge clk); #1;
        rst_n = 1;
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        n_tests++;
        if ({mem_ready, alu_ready, rf_write_enable, err} !== 4'b0 || fifo_count !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got rdy=%b%b we=%b err=%b cnt=%0d, want all 0",
                     mem_ready, alu_ready, rf_write_enable, err, fifo_count);
        end
        n_tests++;
        if (rf_rd !== 5'd0 || rf_write_data !== 64'd0 || idle !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_rf: got rd=%0d data=%0d idle=%b, want 0 0 1",
                     rf_rd, rf_write_data, idle);
        end
        rst_n = 1;
        model_clear();
        #1;
        n_tests++;
        if (mem_ready !== 1'b1 || alu_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready: got %b%b, want 11", mem_ready, alu_ready);
        end
    endtask

    task automatic test_basic();
        issue_reserve = 1; issue_rd = 5; tick(); issue_reserve = 0;
        query_rs1 = 5; #1;
        mem_valid = 1; mem_rd = 5; mem_data = 64'd50; #1;
        n_tests++;
        if (mem_ready !== 1'b1 || rs1_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_accept: got ready=%b busy=%b, want 1 1", mem_ready, rs1_busy);
        end
        tick(); mem_valid = 0; #1;
        n_tests++;
        if (rs1_busy !== 1'b1 || fifo_count !== 3'd1) begin
            n_fail++;
            $display("FAIL basic_inflight: got busy=%b cnt=%0d, want 1 1", rs1_busy, fifo_count);
        end
        tick();
        n_tests++;
        if (rf_write_enable !== 1'b1 || rf_rd !== 5'd5 || rf_write_data !== 64'd50
            || rs1_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_write: got we=%b rd=%0d data=%0d busy=%b, want 1 5 50 0",
                     rf_write_enable, rf_rd, rf_write_data, rs1_busy);
        end
    endtask

    task automatic test_x0();
        alu_valid = 1; alu_rd = 0; alu_data = 64'd30; #1;
        n_tests++;
        if (alu_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL x0_accept: got alu_ready=%b, want 1", alu_ready);
        end
        tick(); alu_valid = 0;
        tick();
        n_tests++;
        if (rf_write_enable !== 1'b0 || err !== 1'b0 || fifo_count !== 3'd0) begin
            n_fail++;
            $display("FAIL x0_drop: got we=%b err=%b cnt=%0d, want 0 0 0",
                     rf_write_enable, err, fifo_count);
        end
    endtask

    task automatic test_priority();
        issue_reserve = 1; issue_rd = 3; tick();
        issue_rd = 4; tick(); issue_reserve = 0;
        mem_valid = 1; mem_rd = 3; mem_data = 64'd300;
        alu_valid = 1; alu_rd = 4; alu_data = 64'd20; #1;
        n_tests++;
        if (mem_ready !== 1'b1 || alu_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL prio_ready: got mem=%b alu=%b, want 1 0", mem_ready, alu_ready);
        end
        tick(); mem_valid = 0; #1;
        n_tests++;
        if (alu_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL prio_alu_next: got alu_ready=%b, want 1", alu_ready);
        end
        tick(); alu_valid = 0;
        n_tests++;
        if (rf_write_enable !== 1'b1 || rf_rd !== 5'd3 || rf_write_data !== 64'd300) begin
            n_fail++;
            $display("FAIL prio_first: got we=%b rd=%0d data=%0d, want 1 3 300",
                     rf_write_enable, rf_rd, rf_write_data);
        end
        tick();
        n_tests++;
        if (rf_write_enable !== 1'b1 || rf_rd !== 5'd4 || rf_write_data !== 64'd20
            || err !== 1'b0) begin
            n_fail++;
            $display("FAIL prio_second: got we=%b rd=%0d data=%0d err=%b, want 1 4 20 0",
                     rf_write_enable, rf_rd, rf_write_data, err);
        end
    endtask

    task automatic test_err();
        issue_reserve = 1; issue_rd = 7; tick();
        n_tests++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("FAIL err_first_reserve: got err=%b, want 0", err);
        end
        tick(); issue_reserve = 0;
        tick(); tick();
        n_tests++;
        if (err !== 1'b1) begin
            n_fail++;
            $display("FAIL err_waw_sticky: got err=%b, want 1", err);
        end
        do_reset();
        n_tests++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("FAIL err_cleared: got err=%b, want 0", err);
        end
        // x9: pop of x9 lands on the same edge as its re-reservation.
        issue_reserve = 1; issue_rd = 9; tick(); issue_reserve = 0;
        mem_valid = 1; mem_rd = 9; mem_data = 64'd99; tick(); mem_valid = 0;
        issue_reserve = 1; issue_rd = 9; tick(); issue_reserve = 0;
        query_rs2 = 9; #1;
        n_tests++;
        if (rs2_busy !== 1'b1 || rf_rd !== 5'd9 || rf_write_enable !== 1'b1) begin
            n_fail++;
            $display("FAIL set_wins: got busy=%b rd=%0d we=%b, want 1 9 1",
                     rs2_busy, rf_rd, rf_write_enable);
        end
        do_reset();
    endtask

    task automatic test_random();
        int   plist[$];
        int   r, k, cyc;
        for (cyc = 0; cyc < 400; cyc++) begin
            r = $urandom_range(1, 31);
            issue_reserve = ($urandom_range(0, 2) == 0) && !m_pend[r];
            issue_rd = 5'(r);
            plist.delete();
            for (int i = 1; i < 32; i++) if (m_pend[i] && !(issue_reserve && issue_rd == i))
                plist.push_back(i);
            mem_valid = ($urandom_range(0, 2) == 0) && plist.size() > 0;
            alu_valid = ($urandom_range(0, 2) != 0);
            k = (plist.size() > 0) ? plist[$urandom_range(0, plist.size() - 1)] : 0;
            mem_rd = 5'(k);
            k = (plist.size() > 0 && $urandom_range(0, 4) != 0)
              ? plist[$urandom_range(0, plist.size() - 1)] : 0;
            alu_rd = 5'(k);
            mem_data = {$urandom, $urandom};
            alu_data = {$urandom, $urandom};
            query_rs1 = 5'($urandom_range(0, 31));
            query_rs2 = 5'($urandom_range(0, 31));
            #1;
            n_tests++;
            if (mem_ready !== (mq.size() < DEPTH)
                || alu_ready !== ((mq.size() < DEPTH) && !mem_valid)
                || rs1_busy !== m_pend[query_rs1] || rs2_busy !== m_pend[query_rs2]) begin
                n_fail++;
                $display("FAIL rand_comb[%0d]: got rdy=%b%b busy=%b%b, want rdy=%b%b busy=%b%b",
                         cyc, mem_ready, alu_ready, rs1_busy, rs2_busy,
                         mq.size() < DEPTH, (mq.size() < DEPTH) && !mem_valid,
                         m_pend[query_rs1], m_pend[query_rs2]);
            end
            tick();
            n_tests++;
            if (rf_write_enable !== m_we || fifo_count !== 3'(mq.size()) || err !== m_err
                || (m_we && (rf_rd !== m_rd || rf_write_data !== m_data))
                || idle !== (mq.size() == 0 && !m_we)) begin
                n_fail++;
                $display("FAIL rand_seq[%0d]: got we=%b rd=%0d data=%h cnt=%0d err=%b idle=%b, want we=%b rd=%0d data=%h cnt=%0d err=%b",
                         cyc, rf_write_enable, rf_rd, rf_write_data, fifo_count, err, idle,
                         m_we, m_rd, m_data, mq.size(), m_err);
            end
        end
        idle_inputs();
        tick(); tick();
    endtask

    task automatic test_reset_mid();
        bit any_busy;
        issue_reserve = 1; issue_rd = 10; tick();
        issue_rd = 11; tick();
        issue_rd = 12; tick(); issue_reserve = 0;
        mem_valid = 1; mem_rd = 10; mem_data = 64'd1; tick();
        mem_rd = 11; mem_data = 64'd2; tick();
        mem_rd = 12; mem_data = 64'd3; tick(); mem_valid = 0;
        #1;
        rst_n = 0;
        #1;
        n_tests++;
        if (rf_write_enable !== 1'b0 || fifo_count !== 3'd0 || mem_ready !== 1'b0
            || alu_ready !== 1'b0 || idle !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset: got we=%b cnt=%0d rdy=%b%b idle=%b, want 0 0 00 1",
                     rf_write_enable, fifo_count, mem_ready, alu_ready, idle);
        end
        any_busy = 0;
        for (int i = 0; i < 32; i++) begin
            query_rs1 = 5'(i); #1;
            if (rs1_busy !== 1'b0) any_busy = 1;
        end
        n_tests++;
        if (any_busy) begin
            n_fail++;
            $display("FAIL midreset_pending: got some busy=1, want all 0");
        end
        model_clear();
        @(posedge clk); #1;
        rst_n = 1;
        tick();
        n_tests++;
        if (idle !== 1'b1 || mem_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_release: got idle=%b ready=%b, want 1 1", idle, mem_ready);
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_basic();
        test_x0();
        test_priority();
        test_err();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
